// File: rtl/sega_pad_reader.sv
// Sega Genesis DB9 pad poller: drives select through the 8-phase sequence,
// samples the multiplexed pins and commits a 12-bit button frame with press pulses.
module sega_pad_reader #(
    parameter int unsigned PHASE_DIV   = 1000,
    parameter int unsigned IDLE_PHASES = 100
) (
    input  logic        clock_50,
    input  logic        reset_flag,
    input  logic        pad_up,
    input  logic        pad_down,
    input  logic        pad_left,
    input  logic        pad_right,
    input  logic        pad_b_a,
    input  logic        pad_c_start,
    output logic        pad_select,
    output logic [11:0] control_inputs,
    output logic [11:0] buttons_held,
    output logic        controller_connected,
    output logic        six_button,
    output logic        frame_done
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6, ST_P7
    } state_t;

    state_t      state_q;
    logic [15:0] div_q;
    logic [15:0] idle_q;
    logic [5:0]  sync1_q;
    logic [5:0]  sync2_q;

    logic        present_q;
    logic        six_q;
    logic        a_q, b_q, c_q, start_q;
    logic        x_q, y_q, z_q, mode_q;
    logic [3:0]  dir_q;

    logic        p1, p2, p3, p4, p6, p9;
    logic        phase_end;
    logic        idle_last;
    logic [11:0] frame_d;

    // Pins idle high (released), so the synchronisers reset to all ones.
    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {pad_c_start, pad_b_a, pad_right, pad_left, pad_down, pad_up};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        {p9, p6, p4, p3, p2, p1} = ~sync2_q;
        phase_end = (div_q == 16'(PHASE_DIV - 1));
        idle_last = (idle_q == 16'(IDLE_PHASES - 1));
    end

    // Assembled frame; extended buttons are meaningless on a 3-button pad.
    always_comb begin
        frame_d = {mode_q, start_q, z_q, y_q, x_q, c_q, b_q, a_q, dir_q};
        if (!six_q) begin
            frame_d[11]  = 1'b0;
            frame_d[9:7] = 3'b000;
        end
        if (!present_q) begin
            frame_d = '0;
        end
    end

    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            state_q              <= ST_IDLE;
            div_q                <= '0;
            idle_q               <= '0;
            pad_select           <= 1'b1;
            control_inputs       <= '0;
            buttons_held         <= '0;
            controller_connected <= 1'b0;
            six_button           <= 1'b0;
            frame_done           <= 1'b0;
            present_q            <= 1'b0;
            six_q                <= 1'b0;
            a_q                  <= 1'b0;
            b_q                  <= 1'b0;
            c_q                  <= 1'b0;
            start_q              <= 1'b0;
            x_q                  <= 1'b0;
            y_q                  <= 1'b0;
            z_q                  <= 1'b0;
            mode_q               <= 1'b0;
            dir_q                <= '0;
        end else begin
            control_inputs <= '0;
            frame_done     <= 1'b0;
            if (!phase_end) begin
                div_q <= div_q + 16'd1;
            end else begin
                div_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (idle_last) begin
                            idle_q     <= '0;
                            state_q    <= ST_P0;
                            pad_select <= 1'b0;
                        end else begin
                            idle_q <= idle_q + 16'd1;
                        end
                    end
                    ST_P0: begin
                        // A connected pad grounds left/right in the first low phase.
                        present_q  <= p3 & p4;
                        a_q        <= p6;
                        start_q    <= p9;
                        state_q    <= ST_P1;
                        pad_select <= 1'b1;
                    end
                    ST_P1: begin
                        dir_q      <= {p4, p3, p2, p1};
                        b_q        <= p6;
                        c_q        <= p9;
                        state_q    <= ST_P2;
                        pad_select <= 1'b0;
                    end
                    ST_P2: begin
                        state_q    <= ST_P3;
                        pad_select <= 1'b1;
                    end
                    ST_P3: begin
                        state_q    <= ST_P4;
                        pad_select <= 1'b0;
                    end
                    ST_P4: begin
                        six_q      <= p1 & p2 & p3 & p4;
                        state_q    <= ST_P5;
                        pad_select <= 1'b1;
                    end
                    ST_P5: begin
                        z_q        <= p1;
                        y_q        <= p2;
                        x_q        <= p3;
                        mode_q     <= p4;
                        state_q    <= ST_P6;
                        pad_select <= 1'b0;
                    end
                    ST_P6: begin
                        state_q    <= ST_P7;
                        pad_select <= 1'b1;
                    end
                    ST_P7: begin
                        buttons_held         <= frame_d;
                        control_inputs       <= frame_d & ~buttons_held;
                        controller_connected <= present_q;
                        six_button           <= present_q & six_q;
                        frame_done           <= 1'b1;
                        state_q              <= ST_IDLE;
                        pad_select           <= 1'b1;
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        pad_select <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sega_pad_reader.sv
// Directed bench for sega_pad_reader with a behavioural 3/6-button pad
// that follows pad_select.
module tb_sega_pad_reader;

    logic        clock_50;
    logic        reset_flag;
    logic        pad_up, pad_down, pad_left, pad_right, pad_b_a, pad_c_start;
    logic        pad_select;
    logic [11:0] control_inputs;
    logic [11:0] buttons_held;
    logic        controller_connected;
    logic        six_button;
    logic        frame_done;

    sega_pad_reader #(
        .PHASE_DIV   (4),
        .IDLE_PHASES (2)
    ) dut (
        .clock_50             (clock_50),
        .reset_flag           (reset_flag),
        .pad_up               (pad_up),
        .pad_down             (pad_down),
        .pad_left             (pad_left),
        .pad_right            (pad_right),
        .pad_b_a              (pad_b_a),
        .pad_c_start          (pad_c_start),
        .pad_select           (pad_select),
        .control_inputs       (control_inputs),
        .buttons_held         (buttons_held),
        .controller_connected (controller_connected),
        .six_button           (six_button),
        .frame_done           (frame_done)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Pad model: btn uses the control_inputs bit order, active-high.
    logic [11:0] btn;
    logic        model_six;
    logic        attached;
    logic        force_mode;
    int          pad_cnt;
    int          high_run;
    logic        prev_sel;
    logic [5:0]  pins;   // {p9, p6, p4, p3, p2, p1}, active-low

    initial begin
        btn        = '0;
        model_six  = 1'b1;
        attached   = 1'b1;
        force_mode = 1'b0;
        pad_cnt    = 0;
        high_run   = 0;
        prev_sel   = 1'b1;
    end

    // Select falling edges step the pad's phase counter; a long high resets it.
    always @(negedge clock_50) begin
        if (prev_sel && !pad_select) pad_cnt = pad_cnt + 1;
        if (pad_select) begin
            high_run = high_run + 1;
            if (high_run >= 6) pad_cnt = 0;
        end else begin
            high_run = 0;
        end
        prev_sel = pad_select;
    end

    always_comb begin
        pins = 6'b111111;
        if (attached) begin
            if (pad_select) begin
                if (model_six && pad_cnt == 3)
                    pins = ~{btn[6], btn[5], btn[11], btn[7], btn[8], btn[9]};
                else
                    pins = ~{btn[6], btn[5], btn[3], btn[2], btn[1], btn[0]};
                if (!model_six && force_mode && pad_cnt == 3)
                    pins[3] = 1'b0;
            end else begin
                if (model_six && pad_cnt == 3)
                    pins = ~{btn[10], btn[4], 4'b1111};
                else if (model_six && pad_cnt == 4)
                    pins = ~{btn[10], btn[4], 4'b0000};
                else
                    pins = ~{btn[10], btn[4], 1'b1, 1'b1, btn[1], btn[0]};
            end
        end
    end

    assign pad_up      = pins[0];
    assign pad_down    = pins[1];
    assign pad_left    = pins[2];
    assign pad_right   = pins[3];
    assign pad_b_a     = pins[4];
    assign pad_c_start = pins[5];

    // Pulses outside a commit cycle, and frame_done wider than one cycle.
    int   stray_cnt = 0;
    int   fd_double = 0;
    logic prev_fd   = 1'b0;
    always @(negedge clock_50) begin
        if (!frame_done && control_inputs != 12'h000) stray_cnt++;
        if (prev_fd && frame_done) fd_double++;
        prev_fd = frame_done;
    end

    int          cyc;
    logic [39:0] selpat;
    logic [39:0] exp_selpat;

    task automatic wait_frame(output int cycles, output logic [39:0] pat);
        logic done;
        cycles = 0;
        pat    = '0;
        done   = 1'b0;
        while (!done && cycles < 200) begin
            @(negedge clock_50);
            pat = {pat[38:0], pad_select};
            cycles++;
            if (frame_done) done = 1'b1;
        end
        chk("frame_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic frame_chk(input string tag, input logic [11:0] e_ci,
                             input logic [11:0] e_held, input logic e_conn,
                             input logic e_six);
        wait_frame(cyc, selpat);
        chk({tag, "_ci"},   {52'd0, control_inputs}, {52'd0, e_ci});
        chk({tag, "_held"}, {52'd0, buttons_held},   {52'd0, e_held});
        chk({tag, "_conn"}, {63'd0, controller_connected}, {63'd0, e_conn});
        chk({tag, "_six"},  {63'd0, six_button},     {63'd0, e_six});
    endtask

    initial begin
        // Select seen at the 40 negedges following a commit, last one the next commit.
        exp_selpat = '0;
        for (int k = 1; k <= 40; k++) begin
            int ph;
            logic s;
            ph = k / 4;
            if (ph < 2 || ph >= 10) s = 1'b1;
            else s = ((ph - 2) % 2 == 0) ? 1'b0 : 1'b1;
            exp_selpat = {exp_selpat[38:0], s};
        end

        reset_flag = 1'b1;
        repeat (3) @(negedge clock_50);
        chk("rst_sel",  {63'd0, pad_select}, 64'd1);
        chk("rst_ci",   {52'd0, control_inputs}, 64'd0);
        chk("rst_held", {52'd0, buttons_held}, 64'd0);
        chk("rst_conn", {63'd0, controller_connected}, 64'd0);
        chk("rst_six",  {63'd0, six_button}, 64'd0);
        chk("rst_fd",   {63'd0, frame_done}, 64'd0);
        reset_flag = 1'b0;

        // Idle 6-button pad
        frame_chk("idle0", 12'h000, 12'h000, 1'b1, 1'b1);
        chk("first_len", cyc, 40);
        frame_chk("idle1", 12'h000, 12'h000, 1'b1, 1'b1);
        chk("frame_len", cyc, 40);
        chk("sel_pattern", {24'd0, selpat}, {24'd0, exp_selpat});

        // Start held three frames, then released
        btn = 12'h400;
        frame_chk("start1", 12'h400, 12'h400, 1'b1, 1'b1);
        frame_chk("start2", 12'h000, 12'h400, 1'b1, 1'b1);
        frame_chk("start3", 12'h000, 12'h400, 1'b1, 1'b1);
        btn = 12'h000;
        frame_chk("start_rel", 12'h000, 12'h000, 1'b1, 1'b1);

        // Up + A + Z together
        btn = 12'h211;
        frame_chk("uaz", 12'h211, 12'h211, 1'b1, 1'b1);
        btn = 12'h000;
        frame_chk("uaz_rel", 12'h000, 12'h000, 1'b1, 1'b1);

        // 3-button pad with the Mode pin pulled low in P5, C pressed
        model_six  = 1'b0;
        force_mode = 1'b1;
        btn        = 12'h040;
        frame_chk("three_c", 12'h040, 12'h040, 1'b1, 1'b0);
        btn        = 12'h000;
        model_six  = 1'b1;
        force_mode = 1'b0;
        frame_chk("three_rel", 12'h000, 12'h000, 1'b1, 1'b1);

        // No pad, then attach with Right held, detach, reattach
        attached = 1'b0;
        frame_chk("nopad", 12'h000, 12'h000, 1'b0, 1'b0);
        attached = 1'b1;
        btn      = 12'h008;
        frame_chk("attach", 12'h008, 12'h008, 1'b1, 1'b1);
        attached = 1'b0;
        frame_chk("detach", 12'h000, 12'h000, 1'b0, 1'b0);
        attached = 1'b1;
        frame_chk("reattach", 12'h008, 12'h008, 1'b1, 1'b1);
        btn = 12'h000;
        frame_chk("right_rel", 12'h000, 12'h000, 1'b1, 1'b1);

        // Reset during P5 with B held
        btn = 12'h020;
        frame_chk("b_pre", 12'h020, 12'h020, 1'b1, 1'b1);
        repeat (30) @(negedge clock_50);
        reset_flag = 1'b1;
        #1;
        chk("mid_rst_sel",  {63'd0, pad_select}, 64'd1);
        chk("mid_rst_ci",   {52'd0, control_inputs}, 64'd0);
        chk("mid_rst_held", {52'd0, buttons_held}, 64'd0);
        chk("mid_rst_conn", {63'd0, controller_connected}, 64'd0);
        chk("mid_rst_six",  {63'd0, six_button}, 64'd0);
        chk("mid_rst_fd",   {63'd0, frame_done}, 64'd0);
        repeat (3) @(negedge clock_50);
        reset_flag = 1'b0;
        frame_chk("b_post", 12'h020, 12'h020, 1'b1, 1'b1);
        chk("post_rst_len", cyc, 40);

        chk("stray_pulse", stray_cnt, 0);
        chk("fd_width", fd_double, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
